shifter_serial_unit: RTL and testbench

- Multi-cycle, bit-serial counterpart to the combinational operand-2 Shifter.
- Accepts a shift request (type, amount, operand, carry-in) over a valid/ready handshake and performs one 1-bit shift per clock.
- Returns the full ARM-semantics result plus shifter carry-out over a second valid/ready handshake.
- Used by the multi-cycle core variant for register-specified shifts, where amounts reach 255 and carry-out is needed for flag-setting logical ops.

---
 rtl/shifter_serial_unit.sv | 121 ++++++++++++
 tb/tb_shifter_serial_unit.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/shifter_serial_unit.sv
// rtl/shifter_serial_unit.sv - bit-serial ARM operand-2 shifter, one 1-bit shift per clock
module shifter_serial_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       shift_type,
    input  logic [7:0]       shift_num,
    input  logic             not_shift,
    input  logic [WIDTH-1:0] x,
    input  logic             c_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             c_out
);

    localparam int LW = $clog2(WIDTH);
    localparam int CW = $clog2(WIDTH + 2);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [1:0] T_LSL = 2'b00;
    localparam logic [1:0] T_LSR = 2'b01;
    localparam logic [1:0] T_ASR = 2'b10;
    localparam logic [1:0] T_ROR = 2'b11;

    logic [1:0]       r_state;
    logic [1:0]       r_type;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_y;
    logic             r_c;

    logic [31:0]      w_amt_ext;
    logic [LW-1:0]    w_ror_low;
    logic [CW-1:0]    w_n;
    logic             w_c_load;

    assign w_amt_ext = {24'd0, shift_num};
    assign w_ror_low = shift_num[LW-1:0];

    // Linear shifts saturate at WIDTH+1 steps: the extra step pushes a 0 (or sign) into carry.
    always_comb begin
        w_n      = '0;
        w_c_load = c_in;
        if (!not_shift) begin
            if (shift_type == T_ROR) begin
                w_n = CW'(w_ror_low);
                if ((shift_num != 8'd0) && (w_ror_low == '0)) begin
                    w_c_load = x[WIDTH-1];
                end
            end else if (w_amt_ext > 32'(WIDTH + 1)) begin
                w_n = CW'(WIDTH + 1);
            end else begin
                w_n = w_amt_ext[CW-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_type  <= T_LSL;
            r_count <= '0;
            r_y     <= '0;
            r_c     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_y     <= x;
                        r_c     <= w_c_load;
                        r_type  <= shift_type;
                        r_count <= w_n;
                        r_state <= (w_n != '0) ? S_BUSY : S_DONE;
                    end
                end
                S_BUSY: begin
                    case (r_type)
                        T_LSL: begin
                            r_c <= r_y[WIDTH-1];
                            r_y <= {r_y[WIDTH-2:0], 1'b0};
                        end
                        T_LSR: begin
                            r_c <= r_y[0];
                            r_y <= {1'b0, r_y[WIDTH-1:1]};
                        end
                        T_ASR: begin
                            r_c <= r_y[0];
                            r_y <= {r_y[WIDTH-1], r_y[WIDTH-1:1]};
                        end
                        default: begin
                            r_c <= r_y[0];
                            r_y <= {r_y[0], r_y[WIDTH-1:1]};
                        end
                    endcase
                    r_count <= r_count - CW'(1);
                    if (r_count == CW'(1)) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign y         = r_y;
    assign c_out     = r_c;

endmodule

// File: tb/tb_shifter_serial_unit.sv
// tb/tb_shifter_serial_unit.sv - self-checking bench for shifter_serial_unit
module tb_shifter_serial_unit;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  shift_type;
    logic [7:0]  shift_num;
    logic        not_shift;
    logic [31:0] x;
    logic        c_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] y;
    logic        c_out;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_y;
    logic        exp_c;
    int          exp_lat;
    logic        exp_armed = 1'b0;
    logic [31:0] got_y;
    logic        got_c;
    int          got_lat;

    always #5 clk = ~clk;

    shifter_serial_unit #(.WIDTH(32)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .shift_type (shift_type),
        .shift_num  (shift_num),
        .not_shift  (not_shift),
        .x          (x),
        .c_in       (c_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .y          (y),
        .c_out      (c_out)
    );

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("FAIL %s got %h expected %h", nm, got, expv);
        end
    endtask

    // Reference: ARM barrel-shifter result computed directly from the amount.
    task automatic model(input logic [1:0] t, input int amt, input logic ns,
                         input logic [31:0] xv, input logic ci,
                         output logic [31:0] my, output logic mc, output int ml);
        int r;
        my = xv;
        mc = ci;
        ml = 1;
        if (ns || amt == 0) return;
        case (t)
            2'b00: begin
                ml = 1 + ((amt > 33) ? 33 : amt);
                if (amt < 32)       begin my = xv << amt; mc = xv[32-amt]; end
                else if (amt == 32) begin my = 0; mc = xv[0]; end
                else                begin my = 0; mc = 1'b0; end
            end
            2'b01: begin
                ml = 1 + ((amt > 33) ? 33 : amt);
                if (amt < 32)       begin my = xv >> amt; mc = xv[amt-1]; end
                else if (amt == 32) begin my = 0; mc = xv[31]; end
                else                begin my = 0; mc = 1'b0; end
            end
            2'b10: begin
                ml = 1 + ((amt > 33) ? 33 : amt);
                if (amt < 32) begin my = $signed(xv) >>> amt; mc = xv[amt-1]; end
                else          begin my = {32{xv[31]}}; mc = xv[31]; end
            end
            default: begin
                r  = amt % 32;
                ml = 1 + r;
                if (r == 0) begin my = xv; mc = xv[31]; end
                else        begin my = (xv >> r) | (xv << (32 - r)); mc = xv[r-1]; end
            end
        endcase
    endtask

    // Checks the held result on every cycle it is presented.
    always @(negedge clk) begin
        if (reset_n) begin
            if (exp_armed && out_valid) begin
                checks++;
                if (y !== exp_y || c_out !== exp_c) begin
                    errors++;
                    $display("FAIL result got y=%h c=%b expected y=%h c=%b", y, c_out, exp_y, exp_c);
                end
                checks++;
                if (in_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL in_ready_in_done got %b expected 0", in_ready);
                end
            end else if (!exp_armed) begin
                checks++;
                if (out_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL spurious_out_valid got %b expected 0", out_valid);
                end
            end
        end
    end

    // Call at a negedge with the unit idle; returns at the first negedge with out_valid=1.
    task automatic send(input logic [1:0] t, input logic [7:0] a, input logic ns,
                        input logic [31:0] xv, input logic ci);
        model(t, int'(a), ns, xv, ci, exp_y, exp_c, exp_lat);
        chk("in_ready_before_accept", {31'd0, in_ready}, 32'd1);
        shift_type = t; shift_num = a; not_shift = ns; x = xv; c_in = ci;
        in_valid   = 1'b1;
        exp_armed  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid   = 1'b0;
        shift_type = 2'($urandom); shift_num = 8'($urandom); not_shift = 1'($urandom);
        x = $urandom; c_in = 1'($urandom);
        got_lat = 1;
        while (!out_valid && got_lat < 60) begin
            @(negedge clk);
            got_lat++;
        end
        chk("latency", 32'(got_lat), 32'(exp_lat));
        got_y = y;
        got_c = c_out;
    endtask

    task automatic retire(input int hold);
        out_ready = 1'b0;
        repeat (hold) @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        exp_armed = 1'b0;
        out_ready = 1'b0;
        chk("out_valid_after_take", {31'd0, out_valid}, 32'd0);
        chk("in_ready_after_take", {31'd0, in_ready}, 32'd1);
    endtask

    typedef struct {
        logic [1:0]  t;
        logic [7:0]  a;
        logic        ns;
        logic [31:0] xv;
        logic        ci;
        logic [31:0] ey;
        logic        ec;
        int          el;
    } vec_t;

    vec_t vecs[$];

    initial begin
        logic [31:0] my;
        logic        mc;
        int          ml;
        logic [31:0] hy;
        logic        hc;

        reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        shift_type = 2'b00; shift_num = 8'd0; not_shift = 1'b0; x = '0; c_in = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset_y", y, 32'd0);
        chk("reset_c", {31'd0, c_out}, 32'd0);
        reset_n = 1'b1;
        @(negedge clk);
        chk("idle_in_ready", {31'd0, in_ready}, 32'd1);

        // Reset in the middle of LSL 20
        shift_type = 2'b00; shift_num = 8'd20; not_shift = 1'b0; x = 32'hDEADBEEF; c_in = 1'b1;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("midreset_out_valid", {31'd0, out_valid}, 32'd0);
        chk("midreset_y", y, 32'd0);
        chk("midreset_c", {31'd0, c_out}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("postreset_in_ready", {31'd0, in_ready}, 32'd1);
        send(2'b00, 8'd20, 1'b0, 32'h0000_1235, 1'b0);
        chk("postreset_y", got_y, 32'h2350_0000);
        chk("postreset_c", {31'd0, got_c}, 32'd1);
        retire(0);

        vecs.push_back('{2'b00, 8'd1,   1'b0, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFE, 1'b1, 2});
        vecs.push_back('{2'b00, 8'd0,   1'b0, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFF, 1'b0, 1});
        vecs.push_back('{2'b00, 8'd32,  1'b0, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 33});
        vecs.push_back('{2'b01, 8'd31,  1'b0, 32'h80000001, 1'b1, 32'h00000001, 1'b0, 32});
        vecs.push_back('{2'b01, 8'd32,  1'b0, 32'h80000001, 1'b0, 32'h00000000, 1'b1, 33});
        vecs.push_back('{2'b01, 8'd40,  1'b0, 32'h80000001, 1'b1, 32'h00000000, 1'b0, 34});
        vecs.push_back('{2'b10, 8'd31,  1'b0, 32'h80000001, 1'b0, 32'hFFFFFFFF, 1'b0, 32});
        vecs.push_back('{2'b10, 8'd200, 1'b0, 32'h80000001, 1'b0, 32'hFFFFFFFF, 1'b1, 34});
        vecs.push_back('{2'b11, 8'd1,   1'b0, 32'h00000001, 1'b0, 32'h80000000, 1'b1, 2});
        vecs.push_back('{2'b11, 8'd31,  1'b0, 32'h7FFFFFFF, 1'b0, 32'hFFFFFFFE, 1'b1, 32});
        vecs.push_back('{2'b11, 8'd32,  1'b0, 32'h7FFFFFFF, 1'b1, 32'h7FFFFFFF, 1'b0, 1});
        vecs.push_back('{2'b11, 8'd31,  1'b1, 32'h7FFFFFFF, 1'b1, 32'h7FFFFFFF, 1'b1, 1});

        foreach (vecs[i]) begin
            model(vecs[i].t, int'(vecs[i].a), vecs[i].ns, vecs[i].xv, vecs[i].ci, my, mc, ml);
            chk($sformatf("model_y_%0d", i), my, vecs[i].ey);
            chk($sformatf("model_c_%0d", i), {31'd0, mc}, {31'd0, vecs[i].ec});
            chk($sformatf("model_lat_%0d", i), 32'(ml), 32'(vecs[i].el));
            send(vecs[i].t, vecs[i].a, vecs[i].ns, vecs[i].xv, vecs[i].ci);
            chk($sformatf("dut_y_%0d", i), got_y, vecs[i].ey);
            chk($sformatf("dut_c_%0d", i), {31'd0, got_c}, {31'd0, vecs[i].ec});
            retire(0);
        end

        // Backpressure with a pending request that must wait for the take
        send(2'b01, 8'd4, 1'b0, 32'hA5A5_0F0F, 1'b1);
        hy = y; hc = c_out;
        shift_type = 2'b11; shift_num = 8'd8; not_shift = 1'b0; x = 32'h1234_5678; c_in = 1'b0;
        in_valid = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
            chk("bp_y_stable", y, hy);
            chk("bp_c_stable", {31'd0, c_out}, {31'd0, hc});
        end
        retire(0);
        send(2'b11, 8'd8, 1'b0, 32'h1234_5678, 1'b0);
        chk("bp_pending_y", got_y, 32'h7812_3456);
        chk("bp_pending_c", {31'd0, got_c}, 32'd0);
        retire(0);

        // Random back-to-back traffic
        for (int n = 0; n < 200; n++) begin
            logic [7:0] a;
            a = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 40));
            send(2'($urandom), a, ($urandom_range(0, 7) == 0), $urandom, 1'($urandom));
            retire($urandom_range(0, 3));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
